// File: rtl/bidcounter_sweep_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : bidcounter_sweep_ctrl                                             |
// | Brief  : Drives a bidcounter through a programmed triangle sweep.          |
// | Rev    : 1.0                                                               |
// +----------------------------------------------------------------------------+
module bidcounter_sweep_ctrl #(
  parameter int WIDTH   = 4,
  parameter int SWEEP_W = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               abort,
  input  logic [WIDTH-1:0]   hi_lim,
  input  logic [WIDTH-1:0]   lo_lim,
  input  logic [SWEEP_W-1:0] n_sweeps,
  input  logic [WIDTH-1:0]   cnt_count,
  output logic               cnt_ctrl,
  output logic               cnt_reset,
  output logic               busy,
  output logic               done,
  output logic               err,
  output logic [SWEEP_W-1:0] sweep_idx
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_UP   = 2'd1,
    S_DOWN = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t               state_q, state_d;
  logic [WIDTH-1:0]     hi_q, hi_d;
  logic [WIDTH-1:0]     lo_q, lo_d;
  logic [SWEEP_W-1:0]   n_q, n_d;
  logic [SWEEP_W-1:0]   idx_q, idx_d;
  logic                 ctrl_q, ctrl_d;
  logic                 crst_q, crst_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 err_q, err_d;

  logic                 start_ok;
  logic                 turn_down;
  logic                 turn_up;
  logic                 last_leg;

  // Turns are decided one count early because the counter moves on the same
  // edge that the new direction is registered.
  assign start_ok  = (lo_lim < hi_lim) && (n_sweeps != '0);
  assign turn_down = (cnt_count == (hi_q - WIDTH'(1)));
  assign turn_up   = (cnt_count == (lo_q + WIDTH'(1)));
  assign last_leg  = (idx_q == (n_q - SWEEP_W'(1)));

  always_comb begin
    state_d = state_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    n_d     = n_q;
    idx_d   = idx_q;
    ctrl_d  = ctrl_q;
    crst_d  = crst_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        crst_d = 1'b1;
        ctrl_d = 1'b0;
        busy_d = 1'b0;
        if (start) begin
          if (start_ok) begin
            state_d = S_UP;
            hi_d    = hi_lim;
            lo_d    = lo_lim;
            n_d     = n_sweeps;
            idx_d   = '0;
            crst_d  = 1'b0;
            busy_d  = 1'b1;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      S_UP: begin
        if (abort) begin
          state_d = S_IDLE;
          crst_d  = 1'b1;
          ctrl_d  = 1'b0;
          busy_d  = 1'b0;
        end else if (turn_down) begin
          state_d = S_DOWN;
          ctrl_d  = 1'b1;
        end
      end
      S_DOWN: begin
        if (abort) begin
          state_d = S_IDLE;
          crst_d  = 1'b1;
          ctrl_d  = 1'b0;
          busy_d  = 1'b0;
        end else if (turn_up) begin
          ctrl_d = 1'b0;
          if (last_leg) begin
            state_d = S_DONE;
            done_d  = 1'b1;
            crst_d  = 1'b1;
            busy_d  = 1'b0;
            idx_d   = n_q;
          end else begin
            state_d = S_UP;
            idx_d   = idx_q + SWEEP_W'(1);
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        crst_d  = 1'b1;
        ctrl_d  = 1'b0;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = S_IDLE;
        crst_d  = 1'b1;
        ctrl_d  = 1'b0;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      hi_q    <= '0;
      lo_q    <= '0;
      n_q     <= '0;
      idx_q   <= '0;
      ctrl_q  <= 1'b0;
      crst_q  <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      n_q     <= n_d;
      idx_q   <= idx_d;
      ctrl_q  <= ctrl_d;
      crst_q  <= crst_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign cnt_ctrl  = ctrl_q;
  assign cnt_reset = crst_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign err       = err_q;
  assign sweep_idx = idx_q;

endmodule
`default_nettype wire

// File: tb/tb_bidcounter_sweep_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : tb_bidcounter_sweep_ctrl                                          |
// | Brief  : Scoreboard bench for bidcounter_sweep_ctrl with a counter model.  |
// | Rev    : 1.0                                                               |
// +----------------------------------------------------------------------------+
module tb_bidcounter_sweep_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic [3:0] hi_lim = '0;
  logic [3:0] lo_lim = '0;
  logic [7:0] n_sweeps = '0;
  logic [3:0] cnt_count = '0;
  logic       cnt_ctrl, cnt_reset, busy, done, err;
  logic [7:0] sweep_idx;

  int n_checks = 0;
  int n_fail   = 0;
  bit sb_en    = 1'b0;
  int exp_cnt[$];
  int exp_done_cnt[$];
  int exp_done_idx[$];

  bidcounter_sweep_ctrl #(.WIDTH(4), .SWEEP_W(8)) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .hi_lim(hi_lim), .lo_lim(lo_lim), .n_sweeps(n_sweeps),
    .cnt_count(cnt_count), .cnt_ctrl(cnt_ctrl), .cnt_reset(cnt_reset),
    .busy(busy), .done(done), .err(err), .sweep_idx(sweep_idx)
  );

  always #5 clk = ~clk;

  // Behavioural bidcounter
  always @(posedge clk) begin
    if (cnt_reset)     cnt_count <= '0;
    else if (cnt_ctrl) cnt_count <= cnt_count - 4'd1;
    else               cnt_count <= cnt_count + 4'd1;
  end

  task automatic check_val(input string tag, input int obs, input int exp_v);
    n_checks++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp_v, $time);
    end
  endtask

  always @(negedge clk) begin
    if (sb_en && !reset) begin
      if (busy) begin
        if (exp_cnt.size() == 0) check_val("busy_extra", int'(busy), 0);
        else begin
          check_val("count", int'(cnt_count), exp_cnt.pop_front());
          check_val("rst_low", int'(cnt_reset), 0);
        end
      end
      if (done) begin
        if (exp_done_cnt.size() == 0) check_val("done_extra", int'(done), 0);
        else begin
          check_val("done_cnt", int'(cnt_count), exp_done_cnt.pop_front());
          check_val("done_idx", int'(sweep_idx), exp_done_idx.pop_front());
          check_val("done_rst", int'(cnt_reset), 1);
          check_val("done_busy", int'(busy), 0);
        end
      end
    end
  end

  task automatic run_sweep(input int lo, input int hi, input int n, input bit change_mid);
    for (int v = 0; v <= hi; v++) exp_cnt.push_back(v);
    for (int v = hi - 1; v > lo; v--) exp_cnt.push_back(v);
    for (int leg = 1; leg < n; leg++) begin
      for (int v = lo; v <= hi; v++) exp_cnt.push_back(v);
      for (int v = hi - 1; v > lo; v--) exp_cnt.push_back(v);
    end
    exp_done_cnt.push_back(lo);
    exp_done_idx.push_back(n);
    @(negedge clk);
    lo_lim = 4'(lo); hi_lim = 4'(hi); n_sweeps = 8'(n); start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    if (change_mid) begin
      repeat (3) @(negedge clk);
      hi_lim = 4'd3; lo_lim = 4'd0; n_sweeps = 8'd7; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
    end
    for (int i = 0; i < 400 && !done; i++) @(negedge clk);
    if (!done) check_val("done_timeout", int'(done), 1);
    @(negedge clk);
    check_val("post_count", int'(cnt_count), 0);
    check_val("post_busy", int'(busy), 0);
    check_val("post_rst", int'(cnt_reset), 1);
    check_val("sb_left", exp_cnt.size(), 0);
    check_val("sb_done_left", exp_done_cnt.size(), 0);
  endtask

  task automatic check_reset_vals(input string tag);
    check_val({tag, "_crst"}, int'(cnt_reset), 1);
    check_val({tag, "_ctrl"}, int'(cnt_ctrl), 0);
    check_val({tag, "_busy"}, int'(busy), 0);
    check_val({tag, "_done"}, int'(done), 0);
    check_val({tag, "_err"}, int'(err), 0);
    check_val({tag, "_idx"}, int'(sweep_idx), 0);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check_reset_vals("rst");

    sb_en = 1'b1;
    run_sweep(2, 5, 2, 1'b0);
    run_sweep(0, 1, 1, 1'b0);

    // Rejected starts
    @(negedge clk);
    lo_lim = 4'd5; hi_lim = 4'd5; n_sweeps = 8'd1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check_val("err_eq_pulse", int'(err), 1);
    check_val("err_eq_busy", int'(busy), 0);
    check_val("err_eq_crst", int'(cnt_reset), 1);
    @(negedge clk);
    check_val("err_eq_clear", int'(err), 0);
    lo_lim = 4'd0; hi_lim = 4'd3; n_sweeps = 8'd0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check_val("err_n0_pulse", int'(err), 1);
    check_val("err_n0_busy", int'(busy), 0);
    @(negedge clk);
    check_val("err_n0_clear", int'(err), 0);

    // Abort on the second up leg
    sb_en = 1'b0;
    lo_lim = 4'd0; hi_lim = 4'd15; n_sweeps = 8'd3; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 200 && !(busy && sweep_idx == 8'd1 && !cnt_ctrl && cnt_count == 4'd9); i++)
      @(negedge clk);
    check_val("abort_reach", int'(cnt_count), 9);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check_val("abort_busy", int'(busy), 0);
    check_val("abort_done", int'(done), 0);
    check_val("abort_idx", int'(sweep_idx), 1);
    check_val("abort_crst", int'(cnt_reset), 1);
    @(negedge clk);
    check_val("abort_count", int'(cnt_count), 0);
    check_val("abort_nodone", int'(done), 0);

    // Limits changed and start pulsed mid-run
    sb_en = 1'b1;
    run_sweep(1, 6, 1, 1'b1);

    // Reset during DOWN
    sb_en = 1'b0;
    lo_lim = 4'd1; hi_lim = 4'd8; n_sweeps = 8'd2; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 100 && !(busy && cnt_ctrl); i++) @(negedge clk);
    check_val("down_reach", int'(cnt_ctrl), 1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check_reset_vals("midrst");
    @(negedge clk);
    check_val("midrst_count", int'(cnt_count), 0);
    exp_cnt.delete(); exp_done_cnt.delete(); exp_done_idx.delete();
    sb_en = 1'b1;
    run_sweep(2, 5, 2, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
